// File: rtl/reg_fifo_stage_if.sv
// Handshake bundle for reg_fifo_stage: write side (I*), read side (O*) and occupancy.
// REG_FIFO_WATERMARK_EN adds the registered almost_full flag.
interface reg_fifo_stage_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] I;
  logic             I_valid;
  logic             I_ready;
  logic [WIDTH-1:0] O;
  logic             O_valid;
  logic             O_ready;
  logic [CW-1:0]    count;
`ifdef REG_FIFO_WATERMARK_EN
  logic             almost_full;

  modport master (
    output I, I_valid, O_ready,
    input  I_ready, O, O_valid, count, almost_full
  );
  modport slave (
    input  I, I_valid, O_ready,
    output I_ready, O, O_valid, count, almost_full
  );
`else
  modport master (
    output I, I_valid, O_ready,
    input  I_ready, O, O_valid, count
  );
  modport slave (
    input  I, I_valid, O_ready,
    output I_ready, O, O_valid, count
  );
`endif
endinterface

// File: rtl/reg_fifo_stage.sv
// FWFT register-array FIFO feeding the 16-bit register stage input.
// Optional REG_FIFO_WATERMARK_EN: registered almost_full at AF_LEVEL.
module reg_fifo_stage #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = 3
) (
  input logic             CLK,
  input logic             ASYNCRESETN,
  reg_fifo_stage_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_AF   = CW'(AF_LEVEL);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push, pop;

  // Flags come only from registered state: no O_ready -> I_ready path.
  assign bus.I_ready = (count_q != CNT_FULL);
  assign bus.O_valid = (count_q != '0);
  assign bus.O       = mem_q[rd_ptr_q];
  assign bus.count   = count_q;

  assign push = bus.I_valid && bus.I_ready;
  assign pop  = bus.O_valid && bus.O_ready;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = bus.I;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

`ifdef REG_FIFO_WATERMARK_EN
  logic almost_full_q, almost_full_d;

  // Loaded from the next count so it lines up with the count output.
  assign almost_full_d   = (count_d >= CNT_AF);
  assign bus.almost_full = almost_full_q;

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      almost_full_q <= 1'b0;
    end else begin
      almost_full_q <= almost_full_d;
    end
  end
`endif

endmodule
